// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, ALU op encoding and issue/tag types for alu_share_arbiter
package alu_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int OP_W     = 3;
  localparam int TAG_ID_W = 8;

  // Op select seen by the shared ALU wrapper; add_sub and logic_arithmetic qualify ADD and SRL.
  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SLL  = 3'd1;
  localparam logic [OP_W-1:0] OP_SLT  = 3'd2;
  localparam logic [OP_W-1:0] OP_SLTU = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_SRL  = 3'd5;
  localparam logic [OP_W-1:0] OP_OR   = 3'd6;
  localparam logic [OP_W-1:0] OP_AND  = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [OP_W-1:0]   operation;
    logic              logic_arithmetic;
    logic              add_sub;
  } issue_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input logic [TAG_ID_W-1:0] id);
    tag_t t;
    t.valid = valid;
    t.id    = valid ? id : '0;
    return t;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU issue and response bundle for alu_share_arbiter
// ALU_ARB_PERF_EN adds perf_clr / perf_grant_cnt to the bundle.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import alu_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_operand_a;
  logic [NUM_REQ*DATA_W-1:0] req_operand_b;
  logic [NUM_REQ*OP_W-1:0]   req_operation;
  logic [NUM_REQ-1:0]        req_logic_arithmetic;
  logic [NUM_REQ-1:0]        req_add_sub;

  logic [DATA_W-1:0]         alu_operand_a;
  logic [DATA_W-1:0]         alu_operand_b;
  logic [OP_W-1:0]           alu_operation;
  logic                      alu_logic_arithmetic;
  logic                      alu_add_sub;
  logic [DATA_W-1:0]         alu_result;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

`ifdef ALU_ARB_PERF_EN
  logic                      perf_clr;
  logic [NUM_REQ*16-1:0]     perf_grant_cnt;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_operation,
           req_logic_arithmetic, req_add_sub, alu_result, perf_clr,
    input  req_ready, alu_operand_a, alu_operand_b, alu_operation,
           alu_logic_arithmetic, alu_add_sub, rsp_valid, rsp_id, rsp_data,
           perf_grant_cnt
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_operation,
           req_logic_arithmetic, req_add_sub, alu_result, perf_clr,
    output req_ready, alu_operand_a, alu_operand_b, alu_operation,
           alu_logic_arithmetic, alu_add_sub, rsp_valid, rsp_id, rsp_data,
           perf_grant_cnt
  );
`else
  modport master (
    output req_valid, req_operand_a, req_operand_b, req_operation,
           req_logic_arithmetic, req_add_sub, alu_result,
    input  req_ready, alu_operand_a, alu_operand_b, alu_operation,
           alu_logic_arithmetic, alu_add_sub, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_operation,
           req_logic_arithmetic, req_add_sub, alu_result,
    output req_ready, alu_operand_a, alu_operand_b, alu_operation,
           alu_logic_arithmetic, alu_add_sub, rsp_valid, rsp_id, rsp_data
  );
`endif

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - generic round-robin arbiter, one-hot grant plus index
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] idx;
  int              cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      idx = ID_W'(cand);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Reset points at the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else if (grant_any) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one pipelined ALU across NUM_REQ requesters
// ALU_ARB_PERF_EN adds saturating per-requester grant counters.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 2
) (
  input logic               clk,
  input logic               rstn,
  alu_share_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  issue_t             sel_issue;
  issue_t             issue_q;
  tag_t               issue_tag_q;
  tag_t               tag_pipe [LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    sel_issue = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_issue.operand_a        = bus.req_operand_a[i*DATA_W +: DATA_W];
        sel_issue.operand_b        = bus.req_operand_b[i*DATA_W +: DATA_W];
        sel_issue.operation        = bus.req_operation[i*OP_W +: OP_W];
        sel_issue.logic_arithmetic = bus.req_logic_arithmetic[i];
        sel_issue.add_sub          = bus.req_add_sub[i];
      end
    end
  end

  // The issue tag rides alongside the issue registers; the LATENCY-deep tag pipe
  // then lines it up with alu_result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_q     <= '0;
      issue_tag_q <= '0;
    end else begin
      if (grant_any) issue_q <= sel_issue;
      issue_tag_q <= make_tag(grant_any, TAG_ID_W'(grant_idx));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag_q;
      for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign bus.alu_operand_a        = issue_q.operand_a;
  assign bus.alu_operand_b        = issue_q.operand_b;
  assign bus.alu_operation        = issue_q.operation;
  assign bus.alu_logic_arithmetic = issue_q.logic_arithmetic;
  assign bus.alu_add_sub          = issue_q.add_sub;

  assign bus.rsp_valid = tag_pipe[LATENCY-1].valid;
  assign bus.rsp_id    = ID_W'(tag_pipe[LATENCY-1].id);
  assign bus.rsp_data  = bus.alu_result;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_cnt [NUM_REQ];

  // Clear takes priority over a grant in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.perf_clr) begin
          perf_cnt[i] <= '0;
        end else if (grant[i] && (perf_cnt[i] != 16'hFFFF)) begin
          perf_cnt[i] <= perf_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
    assign bus.perf_grant_cnt[g*16 +: 16] = perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with reference model
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LATENCY = 2;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic la, input logic sub);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_ADD:  return sub ? a - b : a + b;
      OP_SLL:  return a << sh;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_SRL:  return la ? 32'($signed(a) >>> sh) : a >> sh;
      OP_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction

  // Stand-in for the shared ALU wrapper: result appears LATENCY cycles after its inputs change.
  logic [31:0] alu_pipe [LATENCY];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_ref(bus.alu_operand_a, bus.alu_operand_b, bus.alu_operation,
                           bus.alu_logic_arithmetic, bus.alu_add_sub);
    for (int k = 1; k < LATENCY; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign bus.alu_result = alu_pipe[LATENCY-1];

  bit          v         [NUM_REQ];
  logic [31:0] ra        [NUM_REQ];
  logic [31:0] rb        [NUM_REQ];
  logic [2:0]  rop       [NUM_REQ];
  logic        rla       [NUM_REQ];
  logic        ras       [NUM_REQ];
  int          remaining [NUM_REQ];
  exp_t        expq [$];
  int          grant_log [$];
  int          ptr;
  int          cyc;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic new_op(input int i);
    ra[i]  = $urandom;
    rb[i]  = $urandom;
    rop[i] = 3'($urandom_range(0, 7));
    rla[i] = 1'($urandom_range(0, 1));
    ras[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]                = v[i];
      bus.req_operand_a[i*32 +: 32]   = ra[i];
      bus.req_operand_b[i*32 +: 32]   = rb[i];
      bus.req_operation[i*3 +: 3]     = rop[i];
      bus.req_logic_arithmetic[i]     = rla[i];
      bus.req_add_sub[i]              = ras[i];
    end
  endtask

  // One clock: check the grant and any due response, then retire the accepted request.
  task automatic cycle();
    int w;
    logic [NUM_REQ-1:0] exp_rdy;
    drive();
    @(negedge clk);
    w = -1;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (w < 0 && v[(ptr + off) % NUM_REQ]) w = (ptr + off) % NUM_REQ;
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("rsp_id", 64'(bus.rsp_id), 64'(expq[0].id));
      check("rsp_data", 64'(bus.rsp_data), 64'(expq[0].data));
      void'(expq.pop_front());
    end else begin
      check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
    end
    if (w >= 0) begin
      expq.push_back('{cyc + 1 + LATENCY, w, alu_ref(ra[w], rb[w], rop[w], rla[w], ras[w])});
      grant_log.push_back(w);
      ptr = w;
      remaining[w]--;
      if (remaining[w] <= 0) v[w] = 1'b0;
      else new_op(w);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_alu_zero(input string tag);
    check({tag, "_alu_a"}, 64'(bus.alu_operand_a), 64'd0);
    check({tag, "_alu_b"}, 64'(bus.alu_operand_b), 64'd0);
    check({tag, "_alu_op"}, 64'({bus.alu_operation, bus.alu_logic_arithmetic, bus.alu_add_sub}), 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0;
      remaining[i] = 0;
    end
    drive();
    rstn = 1'b0;
    expq.delete();
    ptr = NUM_REQ - 1;
    @(negedge clk);
    check_alu_zero("reset");
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && expq.size() > 0; k++) cycle();
    check({tag, "_drained"}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int busy;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rstn     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0; rla[i] = 1'b0; ras[i] = 1'b0;
      remaining[i] = 0;
    end
`ifdef ALU_ARB_PERF_EN
    bus.perf_clr = 1'b0;
`endif
    #1;
    do_reset();

    // Idle after reset.
    repeat (10) cycle();
    check_alu_zero("idle");

    // Requester 1: 5 + 7.
    v[1] = 1'b1; ra[1] = 32'd5; rb[1] = 32'd7; rop[1] = OP_ADD; rla[1] = 1'b0; ras[1] = 1'b0;
    remaining[1] = 1;
    cycle();
    repeat (3) cycle();
    check("add_5_7_done", 64'(expq.size()), 64'd0);

    // Three ops in flight from requester 3, then reset discards them.
    v[3] = 1'b1; remaining[3] = 3; new_op(3);
    repeat (3) cycle();
    do_reset();
    repeat (4) cycle();

    // All four continuously valid: strict rotation from requester 0.
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = 1'b1; remaining[i] = 2; new_op(i);
    end
    repeat (8) cycle();
    check("rotation_len", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) check("rotation_order", 64'(grant_log[k]), 64'(k % NUM_REQ));
    end
    drain("rotation");

    // Requester 2 alone: five back-to-back subtractions 10 - i.
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      v[2] = 1'b1; ra[2] = 32'd10; rb[2] = 32'(i); rop[2] = OP_ADD; rla[2] = 1'b0; ras[2] = 1'b1;
      remaining[2] = 1;
      cycle();
    end
    check("sub_grants", 64'(grant_log.size()), 64'd5);
    drain("sub");

    // Random mix of requesters and ops.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          remaining[i] = $urandom_range(1, 4);
          new_op(i);
        end
      end
      cycle();
    end
    for (int k = 0; k < 100; k++) begin
      busy = 0;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) busy++;
      if (busy > 0) cycle();
    end
    busy = 0;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) busy++;
    check("random_all_served", 64'(busy), 64'd0);
    drain("random");

`ifdef ALU_ARB_PERF_EN
    do_reset();
    check("perf_reset", 64'(bus.perf_grant_cnt[15:0]), 64'd0);
    bus.req_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    #1;
    check("perf_saturate", 64'(bus.perf_grant_cnt[15:0]), 64'hFFFF);
    check("perf_other", 64'(bus.perf_grant_cnt[63:16]), 64'd0);
    bus.perf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.perf_clr = 1'b0;
    check("perf_clear", 64'(bus.perf_grant_cnt[15:0]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
